alu: RTL and testbench
======================

ALU -- requirements
Module: alu

Interface
REQ-001 Parameters: none; datapath fixed at 4 bits, all arithmetic unsigned.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  synchronous active-low reset, sampled on rising clk.
REQ-004 A  input  4  operand A.
REQ-005 B  input  4  operand B.
REQ-006 sel  input  4  operation select (encoding per Function).
REQ-007 c  output  1  carry / borrow / shifted-out bit / flag, registered.
REQ-008 out1  output  4  primary result (low nibble), registered.
REQ-009 out2  output  4  secondary result (high nibble / remainder), registered.

Function
REQ-010 All outputs SHALL be registered; result for A, B and sel sampled at rising edge N appears on c/out1/out2 after edge N; latency exactly 1 cycle, new result every cycle, no handshake.
REQ-011 Any output not listed for an operation SHALL be 0.
REQ-012 sel=0000 add: {c,out1}=A+B (5-bit sum).
REQ-013 sel=0001 subtract: out1=(A-B) mod 16; c=1 when A<B (borrow).
REQ-014 sel=0010 multiply: {out2,out1}=A*B (8-bit product); c=0.
REQ-015 sel=0011 divide: out1=A/B, out2=A%B, c=0; if B=0: out1=4'hF, out2=A, c=1 (divide-by-zero flag).
REQ-016 sel=0100 concat 1: {out2,out1}={A,B}.
REQ-017 sel=0101 concat 2: {out2,out1}={B,A}.
REQ-018 sel=0110 shift left: out1={A[2:0],0}; c=A[3].
REQ-019 sel=0111 shift right (logical): out1={0,A[3:1]}; c=A[0].
REQ-020 sel=1000 AND: out1=A&B.
REQ-021 sel=1001 OR: out1=A|B.
REQ-022 sel=1010 negate A: out1=~A.
REQ-023 sel=1011 negate B: out1=~B.
REQ-024 sel=1100 XOR: out1=A^B.
REQ-025 sel=1101 NAND: out1=~(A&B).
REQ-026 sel=1110 compare: out1={0, A==B, A<B, A>B}; c=(A>B); exactly one of out1[2:0] set.
REQ-027 sel=1111 equality: c=(A==B); out1={000, A==B}.
REQ-028 Boundaries: add 15+15 -> c=1,out1=1110; sub 0-1 -> out1=1111,c=1; mul 15*15 -> out2=1110,out1=0001; sel change takes effect at next edge with no residue from previous op.

Reset
REQ-029 When rst_n=0 at a rising clk edge, c, out1, out2 SHALL all become 0 at that edge, regardless of A/B/sel.
REQ-030 Reset asserted mid-stream SHALL discard the in-flight result; first valid result follows the first edge with rst_n=1.
REQ-031 Outputs before the first reset edge are undefined; benches SHALL apply reset for at least 1 cycle.

Verification
REQ-032 A=1011,B=0101: sel 0000 -> c=1,out1=0000; sel 0001 -> c=0,out1=0110; sel 0010 -> out2=0011,out1=0111.
REQ-033 A=1011,B=0101: sel 0011 -> out1=0010,out2=0001,c=0; B=0000 -> out1=1111,out2=1011,c=1.
REQ-034 A=1011,B=0101: sel 0100 -> out2=1011,out1=0101; 0110 -> out1=0110,c=1; 0111 -> out1=0101,c=1.
REQ-035 A=1011,B=0101: sel 1000..1101 -> out1=0001,1111,0100,1010,1110,1110.
REQ-036 A=1011,B=0101: sel 1110 -> out1=0001,c=1; sel 1111 -> c=0,out1=0000; A=B=0111 sel 1111 -> c=1,out1=0001.
REQ-037 Drive sel=0010,A=B=1111, then rst_n=0 for one edge -> all outputs 0; release -> next edge out2=1110,out1=0001.

Source files
------------

// File: rtl/alu.sv
// -----------------------------------------------------------------------------
// alu -- 4-bit unsigned arithmetic/logic unit with fully registered outputs.
//
// Operands A and B are combined according to sel. The result for the inputs
// present at a rising clk edge appears on c/out1/out2 just after that edge.
// The latency is one cycle, a new result is produced every cycle, and there
// is no handshake.
//
// Ports
//   clk   in   1  clock, all state updates on the rising edge
//   rst_n in   1  synchronous active-low reset, clears every output
//   A     in   4  operand A
//   B     in   4  operand B
//   sel   in   4  operation select
//   c     out  1  carry / borrow / shifted-out bit / flag
//   out1  out  4  primary result (low nibble)
//   out2  out  4  secondary result (high nibble / remainder)
//
// Operation map (outputs not listed are driven to 0)
//   0000 add       {c,out1} = A+B
//   0001 subtract  out1 = A-B mod 16, c = borrow (A<B)
//   0010 multiply  {out2,out1} = A*B
//   0011 divide    out1 = A/B, out2 = A%B; B==0 -> out1=F, out2=A, c=1
//   0100 concat 1  {out2,out1} = {A,B}
//   0101 concat 2  {out2,out1} = {B,A}
//   0110 shl       out1 = A<<1, c = A[3]
//   0111 shr       out1 = A>>1, c = A[0]
//   1000 AND   1001 OR   1010 ~A   1011 ~B   1100 XOR   1101 NAND
//   1110 compare   out1 = {0, A==B, A<B, A>B}, c = A>B
//   1111 equality  out1 = {000, A==B}, c = A==B
// -----------------------------------------------------------------------------
module alu (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic [3:0] sel,
    output logic       c,
    output logic [3:0] out1,
    output logic [3:0] out2
);

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_MUL  = 4'b0010;
    localparam logic [3:0] OP_DIV  = 4'b0011;
    localparam logic [3:0] OP_CAT1 = 4'b0100;
    localparam logic [3:0] OP_CAT2 = 4'b0101;
    localparam logic [3:0] OP_SHL  = 4'b0110;
    localparam logic [3:0] OP_SHR  = 4'b0111;
    localparam logic [3:0] OP_AND  = 4'b1000;
    localparam logic [3:0] OP_OR   = 4'b1001;
    localparam logic [3:0] OP_NOTA = 4'b1010;
    localparam logic [3:0] OP_NOTB = 4'b1011;
    localparam logic [3:0] OP_XOR  = 4'b1100;
    localparam logic [3:0] OP_NAND = 4'b1101;
    localparam logic [3:0] OP_CMP  = 4'b1110;
    localparam logic [3:0] OP_EQ   = 4'b1111;

    // Restoring division of a 4-bit dividend by a non-zero 4-bit divisor.
    // Returns {remainder, quotient}. The partial remainder is one bit wider
    // than the divisor so the trial compare never overflows.
    function automatic logic [7:0] udiv4(input logic [3:0] num, input logic [3:0] den);
        logic [4:0] rem_v;
        logic [3:0] quo_v;
        rem_v = 5'd0;
        quo_v = 4'd0;
        for (int i = 3; i >= 0; i--) begin
            rem_v = {rem_v[3:0], num[i]};
            if (rem_v >= {1'b0, den}) begin
                rem_v    = rem_v - {1'b0, den};
                quo_v[i] = 1'b1;
            end else begin
                quo_v[i] = 1'b0;
            end
        end
        return {rem_v[3:0], quo_v};
    endfunction

    logic       c_q,    c_d;
    logic [3:0] out1_q, out1_d;
    logic [3:0] out2_q, out2_d;

    logic [4:0] sum_s;
    logic [4:0] diff_s;
    logic [7:0] prod_s;
    logic [7:0] divres_s;
    logic       a_eq_b_s;
    logic       a_lt_b_s;
    logic       a_gt_b_s;

    // Shared arithmetic and comparison terms used by the result mux.
    always_comb begin
        sum_s    = {1'b0, A} + {1'b0, B};
        // The fifth bit of the widened difference is the borrow out.
        diff_s   = {1'b0, A} - {1'b0, B};
        prod_s   = {4'd0, A} * {4'd0, B};
        a_eq_b_s = (A == B);
        a_lt_b_s = (A < B);
        a_gt_b_s = (A > B);
        if (B != 4'd0) begin
            divres_s = udiv4(A, B);
        end else begin
            // Divide by zero: quotient saturates to F, remainder keeps A.
            divres_s = {A, 4'hF};
        end
    end

    // Result mux: each operation drives only its own outputs, the rest are 0.
    always_comb begin
        c_d    = 1'b0;
        out1_d = 4'd0;
        out2_d = 4'd0;
        case (sel)
            OP_ADD: begin
                c_d    = sum_s[4];
                out1_d = sum_s[3:0];
            end
            OP_SUB: begin
                c_d    = diff_s[4];
                out1_d = diff_s[3:0];
            end
            OP_MUL: begin
                out2_d = prod_s[7:4];
                out1_d = prod_s[3:0];
            end
            OP_DIV: begin
                c_d    = (B == 4'd0);
                out2_d = divres_s[7:4];
                out1_d = divres_s[3:0];
            end
            OP_CAT1: begin
                out2_d = A;
                out1_d = B;
            end
            OP_CAT2: begin
                out2_d = B;
                out1_d = A;
            end
            OP_SHL: begin
                c_d    = A[3];
                out1_d = {A[2:0], 1'b0};
            end
            OP_SHR: begin
                c_d    = A[0];
                out1_d = {1'b0, A[3:1]};
            end
            OP_AND:  out1_d = A & B;
            OP_OR:   out1_d = A | B;
            OP_NOTA: out1_d = ~A;
            OP_NOTB: out1_d = ~B;
            OP_XOR:  out1_d = A ^ B;
            OP_NAND: out1_d = ~(A & B);
            OP_CMP: begin
                // Exactly one of the three relation bits is ever set.
                c_d    = a_gt_b_s;
                out1_d = {1'b0, a_eq_b_s, a_lt_b_s, a_gt_b_s};
            end
            OP_EQ: begin
                c_d    = a_eq_b_s;
                out1_d = {3'b000, a_eq_b_s};
            end
            default: begin
                c_d    = 1'b0;
                out1_d = 4'd0;
                out2_d = 4'd0;
            end
        endcase
    end

    // Output registers with synchronous active-low clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            c_q    <= 1'b0;
            out1_q <= 4'd0;
            out2_q <= 4'd0;
        end else begin
            c_q    <= c_d;
            out1_q <= out1_d;
            out2_q <= out2_d;
        end
    end

    assign c    = c_q;
    assign out1 = out1_q;
    assign out2 = out2_q;

endmodule

// File: tb/tb_alu.sv
// -----------------------------------------------------------------------------
// tb_alu -- scoreboard bench for alu. The driver applies inputs on the falling
// edge and queues the result a plain-arithmetic reference predicts; the
// monitor pops one expectation after every rising edge and compares.
// -----------------------------------------------------------------------------
module tb_alu;

    typedef struct packed {
        logic       c;
        logic [3:0] out1;
        logic [3:0] out2;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] A, B, sel;
    logic       c;
    logic [3:0] out1, out2;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    bit   done  = 1'b0;

    alu dut (
        .clk  (clk),
        .rst_n(rst_n),
        .A    (A),
        .B    (B),
        .sel  (sel),
        .c    (c),
        .out1 (out1),
        .out2 (out2)
    );

    always #5 clk = ~clk;

    // Reference: each operation computed with integer arithmetic.
    function automatic exp_t model(input int a, input int b, input int s, input bit rst);
        exp_t e;
        int   r;
        e = '0;
        if (rst) return e;
        case (s)
            0:  begin r = a + b; e.out1 = r % 16; e.c = (r >= 16); end
            1:  begin e.out1 = (a - b + 16) % 16; e.c = (a < b); end
            2:  begin r = a * b; e.out1 = r % 16; e.out2 = r / 16; end
            3:  begin
                    if (b == 0) begin e.out1 = 15; e.out2 = a; e.c = 1; end
                    else begin e.out1 = a / b; e.out2 = a % b; end
                end
            4:  begin e.out2 = a; e.out1 = b; end
            5:  begin e.out2 = b; e.out1 = a; end
            6:  begin e.out1 = (a * 2) % 16; e.c = (a >= 8); end
            7:  begin e.out1 = a / 2; e.c = a % 2; end
            8:  e.out1 = a & b;
            9:  e.out1 = a | b;
            10: e.out1 = 15 - a;
            11: e.out1 = 15 - b;
            12: e.out1 = a ^ b;
            13: e.out1 = 15 - (a & b);
            14: begin
                    e.out1 = (a == b) ? 4 : ((a < b) ? 2 : 1);
                    e.c    = (a > b);
                end
            default: begin e.c = (a == b); e.out1 = (a == b) ? 1 : 0; end
        endcase
        return e;
    endfunction

    task automatic drive(input int a, input int b, input int s, input bit rst);
        @(negedge clk);
        A     = 4'(a);
        B     = 4'(b);
        sel   = 4'(s);
        rst_n = ~rst;
        exp_q.push_back(model(a, b, s, rst));
    endtask

    // Monitor: one result per cycle, checked just after the rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                total++;
                if ({c, out1, out2} !== {e.c, e.out1, e.out2}) begin
                    bad++;
                    $display("FAIL result #%0d: got c=%b out1=%b out2=%b, want c=%b out1=%b out2=%b",
                             total, c, out1, out2, e.c, e.out1, e.out2);
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        A     = 4'd0;
        B     = 4'd0;
        sel   = 4'd0;
        // Reset with non-zero inputs present: outputs must still clear.
        drive(15, 15, 2, 1'b1);
        drive(15, 15, 0, 1'b1);
        // Directed vectors with A=1011, B=0101 across every select.
        for (int s = 0; s < 16; s++) drive(11, 5, s, 1'b0);
        drive(11, 0, 3, 1'b0);
        drive(7, 7, 15, 1'b0);
        drive(7, 7, 14, 1'b0);
        drive(3, 9, 14, 1'b0);
        // Boundaries.
        drive(15, 15, 0, 1'b0);
        drive(0, 1, 1, 1'b0);
        drive(15, 15, 2, 1'b0);
        drive(0, 0, 3, 1'b0);
        drive(15, 1, 3, 1'b0);
        // Mid-stream reset discards the in-flight result.
        drive(15, 15, 2, 1'b0);
        drive(15, 15, 2, 1'b1);
        drive(15, 15, 2, 1'b0);
        // Randomized operations, with an occasional reset cycle.
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(15, 0), $urandom_range(15, 0), $urandom_range(15, 0),
                  ($urandom_range(31, 0) == 0));
        end
        // Drain the scoreboard within a bounded number of cycles.
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        #2;
        if (exp_q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain: %0d results outstanding, want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
